// File: rtl/ldst_sequencer.sv
// Moore control sequencer for the Mini SRC load/store class (ld, ldi, st).
// Define LDST_SEQ_TIMEOUT_EN to abort memory waits after MEM_TIMEOUT cycles.
module ldst_sequencer #(
  parameter int                  OPCODE_W    = 5,
  parameter logic [OPCODE_W-1:0] OP_LD       = 5'b00000,
  parameter logic [OPCODE_W-1:0] OP_LDI      = 5'b00001,
  parameter logic [OPCODE_W-1:0] OP_ST       = 5'b00010,
  parameter int                  MEM_TIMEOUT = 15,
  parameter int                  STEP_W      = 4
) (
  input  logic                Clock,
  input  logic                clear,
  input  logic                start,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                PCout,
  output logic                PCin,
  output logic                IncPC,
  output logic                MARin,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                GRA,
  output logic                GRB,
  output logic                Rin,
  output logic                Rout,
  output logic                BAout,
  output logic                Cout,
  output logic                Read,
  output logic                Write,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                mem_err,
  output logic [STEP_W-1:0]   step
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_ERR = 4'd15
  } state_t;

  // C_BAD marks an ERR entered through an undecoded opcode; any other class in ERR is a timeout.
  typedef enum logic [2:0] {C_NONE, C_LD, C_LDI, C_ST, C_BAD} cls_t;

  state_t state, state_next;
  cls_t   cls, cls_next;
  logic   in_wait;
  logic   timeout;

  assign in_wait = (state == S_T1) || (state == S_T6 && cls == C_LD) ||
                   (state == S_T7 && cls == C_ST);

`ifdef LDST_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge Clock) begin
    if (!clear)                   wait_cnt <= '0;
    else if (state_next != state) wait_cnt <= '0;
    else if (in_wait && !mem_ready) wait_cnt <= wait_cnt + CNT_W'(1);
  end

  assign timeout = in_wait && (wait_cnt == CNT_W'(MEM_TIMEOUT));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (!clear) begin
      state <= S_IDLE;
      cls   <= C_NONE;
    end else begin
      state <= state_next;
      cls   <= cls_next;
    end
  end

  always_comb begin
    state_next = state;
    cls_next   = cls;
    case (state)
      S_IDLE: if (start) state_next = S_T0;
      S_T0: begin
        cls_next   = C_NONE;
        state_next = S_T1;
      end
      S_T1: begin
        if (mem_ready)    state_next = S_T2;
        else if (timeout) state_next = S_ERR;
      end
      S_T2: state_next = S_T3;
      S_T3: begin
        state_next = S_T4;
        if (opcode == OP_LD)       cls_next = C_LD;
        else if (opcode == OP_LDI) cls_next = C_LDI;
        else if (opcode == OP_ST)  cls_next = C_ST;
        else begin
          cls_next   = C_BAD;
          state_next = S_ERR;
        end
      end
      S_T4: state_next = S_T5;
      S_T5: state_next = (cls == C_LDI) ? S_IDLE : S_T6;
      S_T6: begin
        if (cls != C_LD || mem_ready) state_next = S_T7;
        else if (timeout)             state_next = S_ERR;
      end
      S_T7: begin
        if (cls != C_ST || mem_ready) state_next = S_IDLE;
        else if (timeout)             state_next = S_ERR;
      end
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout} = '0;
    {GRA, GRB, Rin, Rout, BAout, Cout, Read, Write} = '0;
    {done, illegal, mem_err} = '0;
    busy = (state != S_IDLE);
    step = STEP_W'(state);
    case (state)
      S_T0: {PCout, MARin, IncPC, Zin} = '1;
      S_T1: {Zlowout, PCin, Read, MDRin} = '1;
      S_T2: {MDRout, IRin} = '1;
      S_T3: {GRB, BAout, Yin} = '1;
      S_T4: {Cout, Zin} = '1;
      S_T5: begin
        Zlowout = 1'b1;
        if (cls == C_LDI) {GRA, Rin, done} = '1;
        else              MARin = 1'b1;
      end
      S_T6: begin
        MDRin = 1'b1;
        if (cls == C_ST) {GRA, Rout} = '1;
        else             Read = 1'b1;
      end
      S_T7: begin
        {MDRout, done} = '1;
        if (cls == C_ST) Write = 1'b1;
        else             {GRA, Rin} = '1;
      end
      S_ERR: begin
        illegal = (cls == C_BAD);
`ifdef LDST_SEQ_TIMEOUT_EN
        mem_err = (cls != C_BAD);
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: doc/ldst_sequencer.md
Name: ldst_sequencer

Overview:
- Hardware control sequencer for the load/store class (ld, ldi, st) of the Mini SRC datapath.
- Replaces hand-driven T0..Tn control strobes with a parametrised Moore FSM.
- Adds a memory ready/wait handshake and illegal-opcode detection.
- Drives the Datapath control inputs directly: fetch, decode, effective address (Rb + C), memory access and register write-back, then returns to idle.

Parameters:
- OPCODE_W, 5, width of the opcode field taken from IR.
- OP_LD, 5'b00000, opcode of ld.
- OP_LDI, 5'b00001, opcode of ldi.
- OP_ST, 5'b00010, opcode of st.
- MEM_TIMEOUT, 15, maximum wait cycles on mem_ready before abort (only with macro, see Optional Feature).
- STEP_W, 4, width of the step debug output.

Ports:
- Clock  in  1  system clock, rising edge.
- clear  in  1  synchronous reset, active-low (0 = reset).
- start  in  1  begin instruction; sampled only in IDLE.
- opcode  in  OPCODE_W  IR[31:27] from Datapath; valid from the cycle after IRin.
- mem_ready  in  1  RAM completes the current Read/Write this cycle.
- PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout  out  1 each  datapath strobes.
- GRA, GRB, Rin, Rout, BAout, Cout  out  1 each  select/encode strobes.
- Read, Write  out  1 each  memory strobes.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in the final step of a legal instruction.
- illegal  out  1  one-cycle pulse in ERR caused by an undecoded opcode.
- mem_err  out  1  one-cycle pulse in ERR caused by a memory timeout.
- step  out  STEP_W  current state code: IDLE=0, T0..T7=1..8, ERR=15.

Behaviour:
- Moore FSM. All outputs are decoded only from the registered state and the latched op class; any strobe not listed for a state is 0.
- Reset: clear=0 at a rising edge puts the FSM in IDLE and the op class in NONE. All outputs are 0 and step=0 from the next cycle. Reset overrides start, mid-instruction included. No memory strobe survives reset.
- IDLE: start=1 -> T0. Otherwise stay.
- T0: PCout, MARin, IncPC, Zin -> T1.
- T1: Zlowout, PCin, Read, MDRin. Hold in T1 while mem_ready=0; mem_ready=1 -> T2.
- T2: MDRout, IRin -> T3.
- T3: GRB, BAout, Yin. Decode opcode and latch the class (LD/LDI/ST). Any other opcode -> ERR with illegal; otherwise -> T4.
- T4: Cout, Zin -> T5.
- T5, LD/ST: Zlowout, MARin -> T6.
- T5, LDI: Zlowout, GRA, Rin, done -> IDLE.
- T6, LD: Read, MDRin. Hold while mem_ready=0 -> T7.
- T6, ST: GRA, Rout, MDRin (Read=0, so MDR loads from the bus) -> T7.
- T7, LD: MDRout, GRA, Rin, done -> IDLE.
- T7, ST: MDRout, Write. Hold while mem_ready=0; mem_ready=1 -> done -> IDLE.
- ERR: only illegal or mem_err asserted, for one cycle -> IDLE.
- Latency with zero-wait memory (mem_ready=1 in the first cycle of each access), counted from the T0 cycle through the done cycle:
  - ldi: 6 cycles.
  - ld: 8 cycles.
  - st: 8 cycles.
- Each wait cycle adds 1 cycle.
- start while busy=1 is ignored; no queuing.
- The class is latched in T3, so opcode changes after T3 have no effect.
- mem_ready outside T1/T6(LD)/T7(ST) is ignored.
- busy=0 in the cycle after done. start may be asserted in that same cycle; back-to-back instructions are legal.

Optional Feature:
- Macro LDST_SEQ_TIMEOUT_EN.
- Defined: a wait counter (width ceil(log2(MEM_TIMEOUT+1))) clears on entering each wait state and increments on every cycle with mem_ready=0. If it reaches MEM_TIMEOUT, the FSM goes to ERR and mem_err pulses. Read/Write drop in the ERR cycle. Counter is cleared by reset.
- Not defined: waits indefinitely; mem_err tied to 0; no counter logic.

Test Plan:
- ld, opcode=5'b00000, mem_ready tied 1, one start pulse -> step 1..8, done on step 8, busy high exactly 8 cycles; Rin/GRA only in T7.
- ld with mem_ready low 3 cycles in T1 and 2 cycles in T6 -> T1 held 4 cycles, T6 held 3 cycles, done 13 cycles after T0.
- ldi, opcode=5'b00001 -> done in T5 (cycle 6); MARin/Read never asserted after T1. st, opcode=5'b00010 -> Write only in T7; Rout+GRA in T6; done cycle 8.
- opcode=5'b01011 -> ERR (step=15) after T3, illegal pulses 1 cycle, no done, IDLE next; start during busy has no effect.
- clear=0 during T6 of ld -> all strobes 0 next cycle, step=0, no done. With LDST_SEQ_TIMEOUT_EN and MEM_TIMEOUT=15, mem_ready held 0 in T1 -> mem_err on cycle 17 after entering T1, then IDLE.
